// File: rtl/sync_fifo_pkg.sv
// Shared width helpers and flag reset values for the single-clock flagged FIFO.
package sync_fifo_pkg;

  function automatic int addr_w(input int size);
    return $clog2(size);
  endfunction

  function automatic int cnt_w(input int size);
    return $clog2(size) + 1;
  endfunction

  localparam logic RST_FULL   = 1'b0;
  localparam logic RST_EMPTY  = 1'b1;
  localparam logic RST_AFULL  = 1'b0;
  localparam logic RST_AEMPTY = 1'b1;
  localparam logic RST_ERR    = 1'b0;

endpackage

// File: rtl/sfifo_ram.sv
// Simple dual-port register array: synchronous write, registered read port by
// default, asynchronous read when SYNC_FIFO_FWFT_EN is defined.
module sfifo_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef SYNC_FIFO_FWFT_EN
  logic unused_ok;
  assign unused_ok = &{1'b0, re, rst};
  assign rdata = mem[raddr];
`else
  logic [WIDTH-1:0] rdata_p1;

  // stage p1: read data register, holds until the next accepted read
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata_p1 <= '0;
    else if (re) rdata_p1 <= mem[raddr];
  end

  assign rdata = rdata_p1;
`endif

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with fill count, almost-full/empty thresholds and error
// pulses. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int BUF_SIZE   = 16,
  parameter int BUF_WIDTH  = 8,
  parameter int AFULL_LVL  = BUF_SIZE - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [BUF_WIDTH-1:0]       i_wdata,
  input  logic                       i_w_en,
  input  logic                       i_r_en,
  output logic [BUF_WIDTH-1:0]       o_rdata,
  output logic                       o_buf_full,
  output logic                       o_buf_empty,
  output logic                       o_almost_full,
  output logic                       o_almost_empty,
  output logic [$clog2(BUF_SIZE):0]  o_count,
  output logic                       o_overflow,
  output logic                       o_underflow
);

  localparam int AW = addr_w(BUF_SIZE);
  localparam int CW = cnt_w(BUF_SIZE);
  localparam logic [CW-1:0] FULL_C   = CW'(BUF_SIZE);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LVL);

  logic [AW-1:0]        waddr_q, raddr_q;
  logic [CW-1:0]        count_nxt;
  logic                 wr_ok, rd_ok;
  logic [BUF_WIDTH-1:0] ram_rdata;

  // Acceptance uses the registered flags, so inputs never reach flags combinationally.
  always_comb begin
    wr_ok     = i_w_en && !o_buf_full;
    rd_ok     = i_r_en && !o_buf_empty;
    count_nxt = o_count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = o_count + CW'(1);
      2'b01:   count_nxt = o_count - CW'(1);
      default: count_nxt = o_count;
    endcase
  end

  // stage p1: pointers, count, flags and error pulses
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      waddr_q        <= '0;
      raddr_q        <= '0;
      o_count        <= '0;
      o_buf_full     <= RST_FULL;
      o_buf_empty    <= RST_EMPTY;
      o_almost_full  <= RST_AFULL;
      o_almost_empty <= RST_AEMPTY;
      o_overflow     <= RST_ERR;
      o_underflow    <= RST_ERR;
    end else begin
      if (wr_ok) waddr_q <= waddr_q + AW'(1);
      if (rd_ok) raddr_q <= raddr_q + AW'(1);
      o_count        <= count_nxt;
      o_buf_full     <= (count_nxt == FULL_C);
      o_buf_empty    <= (count_nxt == '0);
      o_almost_full  <= (count_nxt >= AFULL_C);
      o_almost_empty <= (count_nxt <= AEMPTY_C);
      o_overflow     <= i_w_en && o_buf_full;
      o_underflow    <= i_r_en && o_buf_empty;
    end
  end

  sfifo_ram #(
    .DEPTH (BUF_SIZE),
    .WIDTH (BUF_WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk   (i_clk),
    .rst   (i_rst),
    .we    (wr_ok),
    .waddr (waddr_q),
    .wdata (i_wdata),
    .re    (rd_ok),
    .raddr (raddr_q),
    .rdata (ram_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign o_rdata = o_buf_empty ? '0 : ram_rdata;
`else
  assign o_rdata = ram_rdata;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags (BUF_SIZE=8); follows SYNC_FIFO_FWFT_EN
// for read-data timing.
module tb_sync_fifo_flags;

  logic       clk, rst;
  logic [7:0] wdata;
  logic       w_en, r_en;
  logic [7:0] rdata;
  logic       full, empty, afull, aempty, ovf, unf;
  logic [3:0] count;

  int checks = 0;
  int errs   = 0;

  sync_fifo_flags #(
    .BUF_SIZE   (8),
    .BUF_WIDTH  (8),
    .AFULL_LVL  (6),
    .AEMPTY_LVL (2)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_wdata        (wdata),
    .i_w_en         (w_en),
    .i_r_en         (r_en),
    .o_rdata        (rdata),
    .o_buf_full     (full),
    .o_buf_empty    (empty),
    .o_almost_full  (afull),
    .o_almost_empty (aempty),
    .o_count        (count),
    .o_overflow     (ovf),
    .o_underflow    (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One accepted read: FWFT shows the head before the edge, standard after it.
  task automatic read_check(input string tag, input int exp);
    r_en = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
    check(tag, int'(rdata), exp);
    step();
`else
    step();
    check(tag, int'(rdata), exp);
`endif
    r_en = 1'b0;
  endtask

  task automatic write_word(input int d);
    wdata = 8'(d);
    w_en  = 1'b1;
    step();
    w_en  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; w_en = 1'b0; r_en = 1'b0; wdata = 8'h00;
    step();
    step();
    check("rst_count",  int'(count),  0);
    check("rst_empty",  int'(empty),  1);
    check("rst_aempty", int'(aempty), 1);
    check("rst_full",   int'(full),   0);
    check("rst_afull",  int'(afull),  0);
    check("rst_rdata",  int'(rdata),  0);
    check("rst_ovf",    int'(ovf),    0);
    check("rst_unf",    int'(unf),    0);
    rst = 1'b0;
    step();

    // Fill 0x01..0x08 and watch the level flags move
    for (int i = 1; i <= 8; i++) begin
      write_word(i);
      check("fill_count",  int'(count),  i);
      check("fill_empty",  int'(empty),  0);
      check("fill_aempty", int'(aempty), (i <= 2) ? 1 : 0);
      check("fill_afull",  int'(afull),  (i >= 6) ? 1 : 0);
      check("fill_full",   int'(full),   (i == 8) ? 1 : 0);
`ifdef SYNC_FIFO_FWFT_EN
      check("fwft_head", int'(rdata), 1);
`endif
    end

    // Write while full
    write_word(8'hAA);
    check("ovf_pulse", int'(ovf),   1);
    check("ovf_count", int'(count), 8);
    check("ovf_full",  int'(full),  1);
    step();
    check("ovf_clear", int'(ovf),   0);

    for (int i = 1; i <= 8; i++) begin
      read_check("drain_data", i);
      check("drain_count", int'(count), 8 - i);
    end
    check("drain_empty",  int'(empty),  1);
    check("drain_aempty", int'(aempty), 1);

    // Read while empty
    r_en = 1'b1;
    step();
    r_en = 1'b0;
    check("unf_pulse", int'(unf),   1);
    check("unf_count", int'(count), 0);
`ifdef SYNC_FIFO_FWFT_EN
    check("unf_rdata", int'(rdata), 8'h00);
`else
    check("unf_rdata", int'(rdata), 8'h08);
`endif
    step();
    check("unf_clear", int'(unf), 0);

    // Full with simultaneous read and write
    for (int i = 0; i < 8; i++) write_word(8'h10 + i);
    check("full2", int'(full), 1);
    wdata = 8'hEE; w_en = 1'b1;
    read_check("fullrw_data", 8'h10);
    w_en = 1'b0;
    check("fullrw_ovf",   int'(ovf),   1);
    check("fullrw_count", int'(count), 7);
    check("fullrw_full",  int'(full),  0);
    for (int i = 1; i < 8; i++) read_check("fullrw_drain", 8'h10 + i);
    check("fullrw_empty", int'(empty), 1);

    // Empty with simultaneous read and write
    wdata = 8'h33; w_en = 1'b1; r_en = 1'b1;
    step();
    w_en = 1'b0; r_en = 1'b0;
    check("emptyrw_unf",   int'(unf),   1);
    check("emptyrw_count", int'(count), 1);
`ifndef SYNC_FIFO_FWFT_EN
    check("emptyrw_hold", int'(rdata), 8'h17);
`endif
    read_check("emptyrw_data", 8'h33);
    check("emptyrw_empty", int'(empty), 1);

    // Sustained read+write at level 4, pointers wrap
    for (int i = 0; i < 4; i++) write_word(8'h40 + i);
    for (int i = 0; i < 20; i++) begin
      wdata = 8'(8'h44 + i);
      w_en  = 1'b1;
      read_check("stream_data", 8'h40 + i);
      check("stream_count", int'(count), 4);
    end
    w_en = 1'b0;
    for (int i = 0; i < 4; i++) read_check("stream_tail", 8'h54 + i);
    check("stream_empty", int'(empty), 1);

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 5; i++) write_word(8'h60 + i);
    check("pre_rst_count", int'(count), 5);
    wdata = 8'h99; w_en = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("arst_count",  int'(count),  0);
    check("arst_empty",  int'(empty),  1);
    check("arst_aempty", int'(aempty), 1);
    check("arst_afull",  int'(afull),  0);
    check("arst_rdata",  int'(rdata),  0);
    w_en = 1'b0;
    step();
    rst = 1'b0;
    step();
    write_word(8'h5A);
    check("post_rst_count", int'(count), 1);
    read_check("post_rst_data", 8'h5A);
    check("post_rst_empty", int'(empty), 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
